ctlb_refill: RTL and testbench

CTLB_REFILL -- requirements
Module: ctlb_refill

---
 rtl/ctlb_refill.sv | 196 +++++++++++++++++++
 tb/tb_ctlb_refill.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctlb_refill.sv
// Code-TLB refill walker: four-level page-table walk on a code TLB miss.
// Optional large-page (level-1 leaf) support under `CTLB_REFILL_LARGE_PAGE_EN.
module ctlb_refill (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_valid,
  input  logic [51:0] miss_addr,
  input  logic        miss_nat,
  input  logic [39:0] root_ppn,
  input  logic        flush,
  output logic        busy,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rdata_valid,
  input  logic [63:0] mem_rdata,
  output logic        refill_wen,
  output logic [63:0] refill_pte,
  output logic        refill_nat,
  output logic        fault_valid,
  output logic [51:0] fault_addr
);

  localparam int unsigned VPN_W = 52;
  localparam int unsigned PPN_W = 40;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned IDX_W = 9;
  localparam int unsigned LVL_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [LVL_W-1:0] LVL_TOP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             nat_q, nat_d;
  logic             busy_q, busy_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic             refill_wen_q, refill_wen_d;
  logic [XLEN-1:0]  refill_pte_q, refill_pte_d;
  logic             refill_nat_q, refill_nat_d;
  logic             fault_valid_q, fault_valid_d;
  logic [VPN_W-1:0] fault_addr_q, fault_addr_d;

  logic canonical_c;
  logic large_leaf_c;

  // 9-bit table index for a given level of the captured page number
  function automatic logic [IDX_W-1:0] idx_of(input logic [VPN_W-1:0] vpn,
                                               input logic [LVL_W-1:0] lvl);
    logic [IDX_W-1:0] idx;
    case (lvl)
      2'd3:    idx = vpn[35:27];
      2'd2:    idx = vpn[26:18];
      2'd1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return idx;
  endfunction

  function automatic logic [XLEN-1:0] pte_addr(input logic [PPN_W-1:0] ptr,
                                               input logic [IDX_W-1:0] idx);
    return {12'b0, ptr, idx, 3'b000};
  endfunction

  // VA[63:47] must be a sign extension of VA[47]
  assign canonical_c = (&miss_addr[51:35]) | ~(|miss_addr[51:35]);

`ifdef CTLB_REFILL_LARGE_PAGE_EN
  assign large_leaf_c = (lvl_q == 2'd1) && mem_rdata[7];
`else
  assign large_leaf_c = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    lvl_d         = lvl_q;
    vpn_d         = vpn_q;
    nat_d         = nat_q;
    mem_addr_d    = mem_addr_q;
    refill_wen_d  = 1'b0;
    refill_pte_d  = refill_pte_q;
    refill_nat_d  = refill_nat_q;
    fault_valid_d = 1'b0;
    fault_addr_d  = fault_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (miss_valid && !flush) begin
          vpn_d = miss_addr;
          nat_d = miss_nat;
          lvl_d = LVL_TOP;
          if (canonical_c) begin
            state_d    = ST_REQ;
            mem_addr_d = pte_addr(root_ppn, miss_addr[35:27]);
          end else begin
            fault_valid_d = 1'b1;
            fault_addr_d  = miss_addr;
          end
        end
      end

      ST_REQ: begin
        if (flush) begin
          // an acked request still owes us a beat, so it must be drained
          state_d = mem_ack ? ST_DRAIN : ST_IDLE;
        end else if (mem_ack) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // a beat arriving with the flush is the one we would drain
          state_d = mem_rdata_valid ? ST_IDLE : ST_DRAIN;
        end else if (mem_rdata_valid) begin
          if (!mem_rdata[0]) begin
            state_d       = ST_IDLE;
            fault_valid_d = 1'b1;
            fault_addr_d  = vpn_q;
          end else if (lvl_q == 2'd0) begin
            state_d      = ST_IDLE;
            refill_wen_d = 1'b1;
            refill_pte_d = mem_rdata;
            refill_nat_d = nat_q;
          end else if (large_leaf_c) begin
            state_d      = ST_IDLE;
            refill_wen_d = 1'b1;
            refill_pte_d = {mem_rdata[63:21], vpn_q[8:0], mem_rdata[11:0]};
            refill_nat_d = nat_q;
          end else begin
            state_d    = ST_REQ;
            lvl_d      = lvl_q - 2'd1;
            mem_addr_d = pte_addr(mem_rdata[51:12], idx_of(vpn_q, lvl_q - 2'd1));
          end
        end
      end

      ST_DRAIN: begin
        if (mem_rdata_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lvl_q         <= LVL_TOP;
      vpn_q         <= '0;
      nat_q         <= 1'b0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      refill_wen_q  <= 1'b0;
      refill_pte_q  <= '0;
      refill_nat_q  <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      lvl_q         <= lvl_d;
      vpn_q         <= vpn_d;
      nat_q         <= nat_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      refill_wen_q  <= refill_wen_d;
      refill_pte_q  <= refill_pte_d;
      refill_nat_q  <= refill_nat_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign refill_wen  = refill_wen_q;
  assign refill_pte  = refill_pte_q;
  assign refill_nat  = refill_nat_q;
  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_ctlb_refill.sv
// Scoreboard bench for ctlb_refill: stimulus pushes expected requests/refills/faults,
// a monitor pops and compares; a behavioural memory answers the walker.
module tb_ctlb_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [51:0] miss_addr;
  logic        miss_nat;
  logic [39:0] root_ppn;
  logic        flush;
  logic        busy;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic        mem_rdata_valid;
  logic [63:0] mem_rdata;
  logic        refill_wen;
  logic [63:0] refill_pte;
  logic        refill_nat;
  logic        fault_valid;
  logic [51:0] fault_addr;

  ctlb_refill dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_nat(miss_nat), .root_ppn(root_ppn), .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .refill_wen(refill_wen), .refill_pte(refill_pte), .refill_nat(refill_nat),
    .fault_valid(fault_valid), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_pte_q[$];
  logic        exp_nat_q[$];
  logic [51:0] exp_fault_q[$];
  int unsigned exp_fault_cyc_q[$];

  logic [63:0] pte_mem [logic [63:0]];
  int ack_delay = 0;
  int data_delay = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: ack after ack_delay cycles of mem_req, beat data_delay cycles after the WAIT entry
  initial begin : mem_model
    int req_wait;
    int beat_cnt;
    bit pending;
    logic [63:0] beat_addr;
    req_wait = 0; beat_cnt = 0; pending = 0; beat_addr = '0;
    mem_ack = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata_valid = 1'b0;
      if (rst) begin
        pending = 0;
        req_wait = 0;
      end else begin
        if (pending) begin
          if (beat_cnt == 0) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = pte_mem.exists(beat_addr) ? pte_mem[beat_addr] : 64'h0;
            pending = 0;
          end else begin
            beat_cnt--;
          end
        end
        if (mem_req) begin
          if (req_wait >= ack_delay) begin
            mem_ack = 1'b1;
            pending = 1;
            beat_cnt = data_delay;
            beat_addr = mem_addr;
            req_wait = 0;
          end else begin
            req_wait++;
          end
        end else begin
          req_wait = 0;
        end
      end
    end
  end

  initial begin : monitor
    bit          prev_held;
    logic [63:0] prev_addr;
    prev_held = 0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_held = 0;
      end else begin
        if (prev_held && mem_req) chk("mem_addr_stable", mem_addr, prev_addr);
        if (mem_req && mem_ack) begin
          if (exp_addr_q.size() == 0) chk("unexpected_mem_req", mem_addr, 64'h0 - 64'h1);
          else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (refill_wen) begin
          if (exp_pte_q.size() == 0) chk("unexpected_refill", refill_pte, ~refill_pte);
          else begin
            chk("refill_pte", refill_pte, exp_pte_q.pop_front());
            chk("refill_nat", 64'(refill_nat), 64'(exp_nat_q.pop_front()));
          end
        end
        if (fault_valid) begin
          if (exp_fault_q.size() == 0) chk("unexpected_fault", 64'(fault_addr), ~64'(fault_addr));
          else begin
            int unsigned fc;
            chk("fault_addr", 64'(fault_addr), 64'(exp_fault_q.pop_front()));
            fc = exp_fault_cyc_q.pop_front();
            if (fc != 0) chk("fault_cycle", 64'(cyc), 64'(fc));
          end
        end
        if (refill_wen || fault_valid) chk("refill_fault_exclusive", 64'(refill_wen & fault_valid), 64'h0);
        prev_held = mem_req && !mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  task automatic start_walk(input logic [51:0] va, input logic nat, input logic [39:0] root,
                            output int unsigned drv_cyc);
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_addr = va; miss_nat = nat; root_ppn = root;
    drv_cyc = cyc;
    @(posedge clk); #1;
    miss_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    chk({name, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'h0);
    chk({name, "_refill_q_empty"}, 64'(exp_pte_q.size()), 64'h0);
    chk({name, "_fault_q_empty"}, 64'(exp_fault_q.size()), 64'h0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk({name, "_idle_timeout"}, 64'(busy), 64'h0);
    check_drained(name);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 64'(busy), 64'h0);
    chk({name, "_mem_req"}, 64'(mem_req), 64'h0);
    chk({name, "_refill_wen"}, 64'(refill_wen), 64'h0);
    chk({name, "_fault_valid"}, 64'(fault_valid), 64'h0);
    chk({name, "_mem_addr"}, mem_addr, 64'h0);
    chk({name, "_refill_pte"}, refill_pte, 64'h0);
    chk({name, "_fault_addr"}, 64'(fault_addr), 64'h0);
    chk({name, "_refill_nat"}, 64'(refill_nat), 64'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int unsigned dc;
    int n;
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_nat = 1'b0;
    root_ppn = '0; flush = 1'b0;

    pte_mem[64'h10_0000] = 64'h20_0001;
    pte_mem[64'h20_0000] = 64'h30_0001;
    pte_mem[64'h30_0008] = 64'h40_0001;
    pte_mem[64'h40_0008] = 64'h8000_0000_0050_0007;
    pte_mem[64'h11_0000] = 64'h21_0001;
    pte_mem[64'h12_0000] = 64'h22_0001;
    pte_mem[64'h22_0000] = 64'h32_0001;
    pte_mem[64'h32_0008] = 64'h42_0001;
    pte_mem[64'h13_0000] = 64'h23_0001;
    pte_mem[64'h23_0000] = 64'h33_0001;
    pte_mem[64'h33_0008] = 64'h43_0001;
    pte_mem[64'h43_0008] = 64'h1234_5001;
    pte_mem[64'h15_0000] = 64'h25_0001;
    pte_mem[64'h25_0000] = 64'h35_0001;
    pte_mem[64'h35_0000] = 64'h4000_0081;
    pte_mem[64'h4000_0F98] = 64'h777_7001;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Full four-level walk, zero-wait memory
    ack_delay = 0; data_delay = 0;
    exp_addr_q.push_back(64'h10_0000);
    exp_addr_q.push_back(64'h20_0000);
    exp_addr_q.push_back(64'h30_0008);
    exp_addr_q.push_back(64'h40_0008);
    exp_pte_q.push_back(64'h8000_0000_0050_0007); exp_nat_q.push_back(1'b1);
    start_walk(52'h201, 1'b1, 40'h100, dc);
    wait_idle("walk4");

    // Non-present L2 entry faults after two reads
    exp_addr_q.push_back(64'h11_0000);
    exp_addr_q.push_back(64'h21_0000);
    exp_fault_q.push_back(52'h201); exp_fault_cyc_q.push_back(0);
    start_walk(52'h201, 1'b0, 40'h110, dc);
    wait_idle("l2_fault");

    // Non-canonical page: fault the cycle after acceptance, no memory traffic
    start_walk(52'h8_0000_0000_0000, 1'b0, 40'h100, dc);
    exp_fault_q.push_back(52'h8_0000_0000_0000); exp_fault_cyc_q.push_back(dc + 1);
    wait_idle("noncanon");

    // Flush the cycle after the L1 ack: beat drained, no refill
    data_delay = 2;
    exp_addr_q.push_back(64'h12_0000);
    exp_addr_q.push_back(64'h22_0000);
    exp_addr_q.push_back(64'h32_0008);
    start_walk(52'h201, 1'b0, 40'h120, dc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_ack && mem_addr == 64'h32_0008) && n < 100);
    chk("drain_l1_ack_seen", 64'(n < 100), 64'h1);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rdata_valid && n < 100);
    chk("drain_beat_seen", 64'(mem_rdata_valid), 64'h1);
    chk("drain_busy_on_beat", 64'(busy), 64'h1);
    @(negedge clk);
    chk("drain_busy_after_beat", 64'(busy), 64'h0);
    check_drained("drain");

    // Slow ack with a second miss ignored mid-walk
    ack_delay = 5; data_delay = 0;
    exp_addr_q.push_back(64'h13_0000);
    exp_addr_q.push_back(64'h23_0000);
    exp_addr_q.push_back(64'h33_0008);
    exp_addr_q.push_back(64'h43_0008);
    exp_pte_q.push_back(64'h1234_5001); exp_nat_q.push_back(1'b0);
    start_walk(52'h201, 1'b0, 40'h130, dc);
    repeat (3) @(posedge clk);
    #1; miss_valid = 1'b1; miss_addr = 52'h999; miss_nat = 1'b1; root_ppn = 40'h100;
    repeat (3) @(posedge clk);
    #1; miss_valid = 1'b0;
    wait_idle("slow_ack");

    // Flush in REQ before the ack: straight back to idle
    start_walk(52'h201, 1'b0, 40'h140, dc);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("req_flush_busy", 64'(busy), 64'h0);
    chk("req_flush_mem_req", 64'(mem_req), 64'h0);
    check_drained("req_flush");

    // Level-1 entry with PTE[7] set
    ack_delay = 0;
    exp_addr_q.push_back(64'h15_0000);
    exp_addr_q.push_back(64'h25_0000);
    exp_addr_q.push_back(64'h35_0000);
`ifdef CTLB_REFILL_LARGE_PAGE_EN
    exp_pte_q.push_back(64'h4000_0000_401F_3081 & 64'h0000_0000_FFFF_FFFF); exp_nat_q.push_back(1'b1);
`else
    exp_addr_q.push_back(64'h4000_0F98);
    exp_pte_q.push_back(64'h777_7001); exp_nat_q.push_back(1'b1);
`endif
    start_walk(52'h1F3, 1'b1, 40'h150, dc);
    wait_idle("l1_bit7");

    // Reset mid-walk abandons it
    ack_delay = 5;
    start_walk(52'h201, 1'b1, 40'h100, dc);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midwalk_rst");
    @(posedge clk); #1; rst = 1'b0;
    check_drained("midwalk_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
